// File: rtl/jpeg_idct_pkg.sv
// Shared types, constants and helpers for the JPEG IDCT blocks.
package jpeg_idct_pkg;

    typedef enum logic {
        S_ROW = 1'b0,
        S_COL = 1'b1
    } state_t;

    localparam int unsigned N               = 8;
    localparam int unsigned PIX_W           = 8;
    localparam int unsigned FINAL_SHIFT_DEF = 2;
    localparam int unsigned LEVEL_DEF       = 128;
    localparam int unsigned COEF_FRAC       = 13;

    // cos(m*pi/16) scaled by 2^COEF_FRAC, for m = 0..8
    function automatic int cos16(input int m);
        int c;
        case (m)
            0:       c = 8192;
            1:       c = 8035;
            2:       c = 7568;
            3:       c = 6811;
            4:       c = 5793;
            5:       c = 4551;
            6:       c = 3135;
            7:       c = 1598;
            default: c = 0;
        endcase
        return c;
    endfunction

    // Basis weight C(u)*cos((2k+1)*u*pi/16), C(0)=1/sqrt(2), C(u>0)=1
    function automatic int coef(input int u, input int k);
        int m;
        int c;
        if (u == 0) begin
            c = cos16(4);
        end else begin
            m = ((2 * k + 1) * u) % 32;
            if (m <= 8)       c = cos16(m);
            else if (m <= 16) c = -cos16(16 - m);
            else if (m <= 24) c = -cos16(m - 16);
            else              c = cos16(32 - m);
        end
        return c;
    endfunction

    // Saturate a signed value to an unsigned 8-bit pixel
    function automatic logic [PIX_W-1:0] clamp_pix(input int v);
        logic [PIX_W-1:0] p;
        if (v < 0)        p = '0;
        else if (v > 255) p = '1;
        else              p = PIX_W'(v);
        return p;
    endfunction

endpackage

// File: rtl/jpeg_idct_1d.sv
// Combinational 8-point 1-D IDCT, fixed-point basis with floor rounding.
module jpeg_idct_1d
    import jpeg_idct_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [N*DW-1:0] in_vec,
    output logic [N*DW-1:0] out_vec
);

    logic signed [DW-1:0] acc;

    // Sum of weighted inputs per output sample, then drop the fraction
    always_comb begin
        out_vec = '0;
        acc     = '0;
        for (int k = 0; k < N; k++) begin
            acc = '0;
            for (int u = 0; u < N; u++) begin
                acc = acc + $signed(in_vec[u*DW +: DW]) * $signed(DW'(coef(u, k)));
            end
            out_vec[k*DW +: DW] = acc >>> COEF_FRAC;
        end
    end

endmodule

// File: rtl/jpeg_idct_2d_ctrl.sv
// 8x8 2-D IDCT sequencer: row pass into a transpose buffer, then column pass to pixels.
module jpeg_idct_2d_ctrl
    import jpeg_idct_pkg::*;
#(
    parameter int DW          = 32,
    parameter int FINAL_SHIFT = FINAL_SHIFT_DEF,
    parameter int LEVEL       = LEVEL_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      in_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*PIX_W-1:0]   out_col,
    output logic [2:0]           out_idx,
    output logic                 blk_done
);

    state_t               state, state_nx;
    logic [2:0]           row_cnt, col_cnt, ld_idx;
    logic                 row_acc, col_hs, col_load;
    logic [N*DW-1:0]      idct_in, idct_out;
    logic signed [DW-1:0] tbuf [N][N];
    logic signed [DW-1:0] sh;
    logic [N*PIX_W-1:0]   pix;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_ROW;
        else     state <= state_nx;
    end

    // Next-state: leave S_ROW on the 8th row, leave S_COL on the column-7 handshake
    always_comb begin
        state_nx = state;
        case (state)
            S_ROW:   if (in_valid && row_cnt == 3'd7) state_nx = S_COL;
            S_COL:   if (out_valid && out_ready && col_cnt == 3'd7) state_nx = S_ROW;
            default: state_nx = S_ROW;
        endcase
    end

    // Handshake strobes and column select; col_cnt tracks the column held in out_col
    always_comb begin
        in_ready = 1'b0;
        row_acc  = 1'b0;
        col_hs   = 1'b0;
        col_load = 1'b0;
        blk_done = 1'b0;
        ld_idx   = col_cnt;
        case (state)
            S_ROW: begin
                in_ready = 1'b1;
                row_acc  = in_valid;
            end
            S_COL: begin
                col_hs   = out_valid && out_ready;
                blk_done = col_hs && (col_cnt == 3'd7);
                col_load = !out_valid || (col_hs && (col_cnt != 3'd7));
                ld_idx   = out_valid ? col_cnt + 3'd1 : col_cnt;
            end
            default: ;
        endcase
    end

    // Shared 1-D input: incoming row, or a buffer column during the column pass
    always_comb begin
        idct_in = in_row;
        if (state == S_COL) begin
            for (int r = 0; r < N; r++) idct_in[r*DW +: DW] = tbuf[r][ld_idx];
        end
    end

    jpeg_idct_1d #(.DW(DW)) u_idct (
        .in_vec  (idct_in),
        .out_vec (idct_out)
    );

    // Final scale, level shift and clamp of column-pass results
    always_comb begin
        pix = '0;
        sh  = '0;
        for (int r = 0; r < N; r++) begin
            sh = ($signed(idct_out[r*DW +: DW]) >>> FINAL_SHIFT) + $signed(DW'(LEVEL));
            pix[r*PIX_W +: PIX_W] = clamp_pix(32'(sh));
        end
    end

    // Transpose buffer: row-pass results, no reset needed
    always_ff @(posedge clk) begin
        if (row_acc) begin
            for (int k = 0; k < N; k++) tbuf[row_cnt][k] <= idct_out[k*DW +: DW];
        end
    end

    // Counters and registered output column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt   <= '0;
            col_cnt   <= '0;
            out_valid <= 1'b0;
            out_col   <= '0;
            out_idx   <= '0;
        end else begin
            if (row_acc) row_cnt <= row_cnt + 3'd1;
            if (col_hs)  col_cnt <= col_cnt + 3'd1;
            if (col_load) begin
                out_valid <= 1'b1;
                out_col   <= pix;
                out_idx   <= ld_idx;
            end else if (blk_done) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_idct_2d_ctrl.sv
// Self-checking bench for jpeg_idct_2d_ctrl against a floating-point-derived IDCT model.
module tb_jpeg_idct_2d_ctrl;

    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [8*DW-1:0] in_row = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [63:0]    out_col;
    logic [2:0]     out_idx;
    logic           blk_done;

    jpeg_idct_2d_ctrl #(.DW(DW), .FINAL_SHIFT(2), .LEVEL(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_idx   (out_idx),
        .blk_done  (blk_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          stim[$];
    logic [63:0] exp_q[$];
    logic [63:0] cap_col[$];
    logic [2:0]  cap_idx[$];
    logic        cap_done[$];
    int          row0_cyc[$], acc_cyc[$], fv_cyc[$];
    int          stable_err, inready_err, spurious_done;
    longint      ccl[8][8];

    // Basis weights derived from the cosine definition, rounded to 13 fractional bits
    task automatic init_coef();
        real pi, v;
        pi = 3.14159265358979;
        for (int u = 0; u < 8; u++)
            for (int k = 0; k < 8; k++) begin
                v = ((u == 0) ? 1.0 / $sqrt(2.0) : 1.0) * $cos((2 * k + 1) * u * pi / 16.0) * 8192.0;
                ccl[u][k] = (v >= 0.0) ? longint'($rtoi($floor(v + 0.5))) : -longint'($rtoi($floor(-v + 0.5)));
            end
    endtask

    function automatic longint idct1(input longint x[8], input int k);
        longint s = 0;
        for (int u = 0; u < 8; u++) s += ccl[u][k] * x[u];
        return s >>> 13;
    endfunction

    // Expected output columns of block b appended to exp_q
    task automatic model_block(input int b);
        longint t[8][8];
        longint x[8];
        longint z, p;
        logic [63:0] w;
        for (int r = 0; r < 8; r++) begin
            for (int u = 0; u < 8; u++) x[u] = longint'(stim[b*64 + r*8 + u]);
            for (int k = 0; k < 8; k++) t[r][k] = idct1(x, k);
        end
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) x[r] = t[r][c];
            w = '0;
            for (int n = 0; n < 8; n++) begin
                z = idct1(x, n);
                p = (z >>> 2) + 128;
                if (p < 0) p = 0;
                if (p > 255) p = 255;
                w[n*8 +: 8] = 8'(p);
            end
            exp_q.push_back(w);
        end
    endtask

    function automatic logic [8*DW-1:0] row_word(input int b, input int r);
        logic [8*DW-1:0] w;
        for (int u = 0; u < 8; u++) w[u*DW +: DW] = DW'(stim[b*64 + r*8 + u]);
        return w;
    endfunction

    // kind 0: DC-only block with value dc; kind 1: random coefficients
    task automatic add_block(input int kind, input int dc);
        for (int i = 0; i < 64; i++) begin
            if (kind == 0) stim.push_back((i == 0) ? dc : 0);
            else if (i == 0) stim.push_back(int'($urandom_range(0, 1200)) - 600);
            else stim.push_back(int'($urandom_range(0, 300)) - 150);
        end
        model_block(stim.size() / 64 - 1);
    endtask

    task automatic clear_caps();
        exp_q.delete(); cap_col.delete(); cap_idx.delete(); cap_done.delete();
        row0_cyc.delete(); acc_cyc.delete(); fv_cyc.delete();
        stable_err = 0; inready_err = 0; spurious_done = 0;
    endtask

    // Drive nblk blocks from stim starting at first_blk and capture every column handshake
    task automatic run(input int first_blk, input int nblk, input int gap_pct,
                       input int stall_pct, input int stop_cols, output int timed_out);
        int sent = 0, got = 0, cyc = 0, need;
        logic prev_stall = 1'b0, col_phase = 1'b0, waitfirst = 1'b0;
        logic [63:0] prev_col = '0;
        logic [2:0]  prev_idx = '0;
        need = (stop_cols > 0) ? stop_cols : nblk * 8;
        while (got < need && cyc < 3000) begin
            @(negedge clk);
            if (col_phase) begin
                in_valid = 1'($urandom_range(0, 1));
                in_row   = {8{$urandom}};
            end else if (sent < nblk * 8 && int'($urandom_range(0, 99)) >= gap_pct) begin
                in_valid = 1'b1;
                in_row   = row_word(first_blk + sent / 8, sent % 8);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (int'($urandom_range(0, 99)) >= stall_pct);
            #1;
            if (col_phase && in_ready) inready_err++;
            if (prev_stall && (!out_valid || out_col !== prev_col || out_idx !== prev_idx)) stable_err++;
            if (blk_done && !(out_valid && out_ready && out_idx == 3'd7)) spurious_done++;
            if (waitfirst && out_valid) begin
                fv_cyc.push_back(cyc);
                waitfirst = 1'b0;
            end
            if (!col_phase && in_valid && in_ready) begin
                if (sent % 8 == 0) row0_cyc.push_back(cyc);
                sent++;
                if (sent % 8 == 0) begin
                    acc_cyc.push_back(cyc);
                    col_phase = 1'b1;
                    waitfirst = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                cap_col.push_back(out_col);
                cap_idx.push_back(out_idx);
                cap_done.push_back(blk_done);
                got++;
                if (got % 8 == 0) col_phase = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            prev_col   = out_col;
            prev_idx   = out_idx;
            cyc++;
        end
        timed_out = (got < need) ? 1 : 0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, out_col, out_idx, blk_done, in_ready} !== {1'b0, 64'h0, 3'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold got v=%b col=%h idx=%0d done=%b rdy=%b required 0 0 0 0 1",
                     out_valid, out_col, out_idx, blk_done, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_col, out_idx, blk_done, in_ready} !== {1'b0, 64'h0, 3'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release got v=%b col=%h idx=%0d done=%b rdy=%b required 0 0 0 0 1",
                     out_valid, out_col, out_idx, blk_done, in_ready);
        end
    endtask

    task automatic test_dc_blocks();
        int base, to;
        int dcs[5] = '{0, 80, -1024, 1024, -4000};
        int pixv[5] = '{128, 137, 0, 255, 0};
        logic [7:0] pv;
        clear_caps();
        base = stim.size() / 64;
        for (int b = 0; b < 5; b++) add_block(0, dcs[b]);
        run(base, 5, 0, 0, 0, to);
        checks++;
        if (to != 0) begin errors++; $display("FAIL dc_timeout got %0d cols required 40", cap_col.size()); end
        for (int i = 0; i < cap_col.size() && i < 40; i++) begin
            pv = 8'(pixv[i / 8]);
            checks++;
            if (cap_col[i] !== {8{pv}}) begin
                errors++;
                $display("FAIL dc_pix blk %0d col %0d got %h required %h", i / 8, i % 8, cap_col[i], {8{pv}});
            end
            checks++;
            if (cap_idx[i] !== 3'(i % 8) || cap_done[i] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL dc_idx_done blk %0d got idx=%0d done=%b required idx=%0d done=%b",
                         i / 8, cap_idx[i], cap_done[i], i % 8, (i % 8 == 7));
            end
        end
        for (int b = 0; b < fv_cyc.size() && b < acc_cyc.size(); b++) begin
            checks++;
            if (fv_cyc[b] != acc_cyc[b] + 2) begin
                errors++;
                $display("FAIL dc_latency blk %0d got first valid cycle %0d required %0d", b, fv_cyc[b], acc_cyc[b] + 2);
            end
        end
        for (int b = 1; b < row0_cyc.size(); b++) begin
            checks++;
            if (row0_cyc[b] - row0_cyc[b-1] != 17) begin
                errors++;
                $display("FAIL dc_period blk %0d got %0d cycles required 17", b, row0_cyc[b] - row0_cyc[b-1]);
            end
        end
        checks++;
        if (spurious_done != 0 || inready_err != 0) begin
            errors++;
            $display("FAIL dc_flags got spurious_done=%0d inready_err=%0d required 0 0", spurious_done, inready_err);
        end
    endtask

    task automatic test_backpressure();
        int base, to;
        clear_caps();
        base = stim.size() / 64;
        for (int b = 0; b < 4; b++) add_block(1, 0);
        run(base, 4, 25, 45, 0, to);
        checks++;
        if (cap_col.size() != 32 || to != 0) begin
            errors++;
            $display("FAIL bp_count got %0d cols required 32", cap_col.size());
        end
        for (int i = 0; i < 32 && i < cap_col.size(); i++) begin
            checks++;
            if (cap_col[i] !== exp_q[i] || cap_idx[i] !== 3'(i % 8) || cap_done[i] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL bp_col %0d got %h idx=%0d done=%b required %h idx=%0d done=%b",
                         i, cap_col[i], cap_idx[i], cap_done[i], exp_q[i], i % 8, (i % 8 == 7));
            end
        end
        checks++;
        if (stable_err != 0 || inready_err != 0 || spurious_done != 0) begin
            errors++;
            $display("FAIL bp_flags got stable=%0d inready=%0d spurious_done=%0d required 0 0 0",
                     stable_err, inready_err, spurious_done);
        end
    endtask

    task automatic test_back_to_back();
        int base, to;
        clear_caps();
        base = stim.size() / 64;
        for (int b = 0; b < 3; b++) add_block(1, 0);
        run(base, 3, 0, 0, 0, to);
        checks++;
        if (cap_col.size() != 24 || to != 0) begin
            errors++;
            $display("FAIL b2b_count got %0d cols required 24", cap_col.size());
        end
        for (int i = 0; i < 24 && i < cap_col.size(); i++) begin
            checks++;
            if (cap_col[i] !== exp_q[i] || cap_idx[i] !== 3'(i % 8)) begin
                errors++;
                $display("FAIL b2b_col %0d got %h idx=%0d required %h idx=%0d", i, cap_col[i], cap_idx[i], exp_q[i], i % 8);
            end
        end
        for (int b = 1; b < row0_cyc.size(); b++) begin
            checks++;
            if (row0_cyc[b] - row0_cyc[b-1] != 17) begin
                errors++;
                $display("FAIL b2b_period blk %0d got %0d required 17", b, row0_cyc[b] - row0_cyc[b-1]);
            end
        end
        for (int b = 0; b < fv_cyc.size() && b < acc_cyc.size(); b++) begin
            checks++;
            if (fv_cyc[b] != acc_cyc[b] + 2) begin
                errors++;
                $display("FAIL b2b_latency blk %0d got %0d required %0d", b, fv_cyc[b], acc_cyc[b] + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, to;
        // five rows, then reset
        clear_caps();
        base = stim.size() / 64;
        add_block(1, 0);
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_row   = row_word(base, r);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_col, out_idx, blk_done, in_ready} !== {1'b0, 64'h0, 3'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_rows got v=%b col=%h idx=%0d done=%b rdy=%b required 0 0 0 0 1",
                     out_valid, out_col, out_idx, blk_done, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        // fresh block after row-phase reset
        clear_caps();
        base = stim.size() / 64;
        add_block(1, 0);
        run(base, 1, 20, 30, 0, to);
        checks++;
        if (cap_col.size() != 8 || to != 0) begin
            errors++;
            $display("FAIL rst1_count got %0d required 8", cap_col.size());
        end
        for (int i = 0; i < 8 && i < cap_col.size(); i++) begin
            checks++;
            if (cap_col[i] !== exp_q[i] || cap_idx[i] !== 3'(i)) begin
                errors++;
                $display("FAIL rst1_col %0d got %h idx=%0d required %h idx=%0d", i, cap_col[i], cap_idx[i], exp_q[i], i);
            end
        end
        // four columns out, then reset
        clear_caps();
        base = stim.size() / 64;
        add_block(1, 0);
        run(base, 1, 0, 20, 4, to);
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_col, out_idx, blk_done, in_ready} !== {1'b0, 64'h0, 3'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_cols got v=%b col=%h idx=%0d done=%b rdy=%b required 0 0 0 0 1",
                     out_valid, out_col, out_idx, blk_done, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        // fresh block after column-phase reset
        clear_caps();
        base = stim.size() / 64;
        add_block(1, 0);
        run(base, 1, 10, 10, 0, to);
        checks++;
        if (cap_col.size() != 8 || to != 0) begin
            errors++;
            $display("FAIL rst2_count got %0d required 8", cap_col.size());
        end
        for (int i = 0; i < 8 && i < cap_col.size(); i++) begin
            checks++;
            if (cap_col[i] !== exp_q[i] || cap_idx[i] !== 3'(i) || cap_done[i] !== (i == 7)) begin
                errors++;
                $display("FAIL rst2_col %0d got %h idx=%0d done=%b required %h idx=%0d done=%b",
                         i, cap_col[i], cap_idx[i], cap_done[i], exp_q[i], i, (i == 7));
            end
        end
    endtask

    initial begin
        init_coef();
        test_reset();
        test_dc_blocks();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
